// File: rtl/fp_rf_pkg.sv
// Shared constants and helpers for the FP register file with scoreboard.
package fp_rf_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned NFWD = 3;
    localparam int unsigned CW   = 2;

    // Decode a register address to a one-hot register select vector.
    function automatic logic [NREG-1:0] addr_onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (a == AW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/fpr_pending_ctr.sv
// Saturating up/down counter of in-flight writes for one FP register.
module fpr_pending_ctr #(
    parameter int unsigned CW = 2
) (
    input  logic       clk,
    input  logic       i_clrn,
    input  logic       i_inc,
    input  logic [1:0] i_dec,
    output logic       o_zero,
    output logic       o_full
);

    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_up;
    logic [CW:0]   w_dec;
    logic [CW-1:0] w_nxt;

    assign o_zero = (r_cnt == '0);
    assign o_full = (r_cnt == '1);

    // Apply the issue first, then the retirements; clamp at zero on underflow.
    always_comb begin
        w_up  = {1'b0, r_cnt} + (CW+1)'(i_inc & ~o_full);
        w_dec = (CW+1)'(i_dec);
        w_nxt = '0;
        if (w_up >= w_dec) begin
            w_nxt = CW'(w_up - w_dec);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_clrn) begin
            r_cnt <= '0;
        end else begin
            assert (w_up >= w_dec)
                else $error("fpr_pending_ctr: retirement without pending issue");
            r_cnt <= w_nxt;
        end
    end

endmodule

// File: rtl/fpr_scoreboard_rf.sv
// FP register file with FPU forwarding, write bypass and per-register scoreboard.
module fpr_scoreboard_rf #(
    parameter int unsigned DW   = fp_rf_pkg::DW,
    parameter int unsigned NREG = fp_rf_pkg::NREG,
    parameter int unsigned AW   = fp_rf_pkg::AW,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NFWD = fp_rf_pkg::NFWD,
    parameter int unsigned CW   = fp_rf_pkg::CW
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rn,
    output logic [NRD*DW-1:0] qd,
    output logic              rd_stall,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_n,
    output logic              iss_full,
    input  logic              wx_en,
    input  logic [AW-1:0]     wx_n,
    input  logic [DW-1:0]     wx_d,
    input  logic              wy_en,
    input  logic [AW-1:0]     wy_n,
    input  logic [DW-1:0]     wy_d,
    input  logic              wy_pend,
    input  logic [NFWD-1:0]   fwd_v,
    input  logic [NFWD-1:0]   fwd_rdy,
    input  logic [NFWD*AW-1:0] fwd_n,
    input  logic [NFWD*DW-1:0] fwd_d,
    output logic [NREG-1:0]   busy
);

    import fp_rf_pkg::*;

    logic [DW-1:0]   r_mem [NREG];
    logic [NREG-1:0] w_iss_oh;
    logic [NREG-1:0] w_wx_oh;
    logic [NREG-1:0] w_wy_oh;
    logic [NREG-1:0] w_zero;
    logic [NREG-1:0] w_full;
    logic [DW-1:0]   w_q  [NRD];
    logic [NRD-1:0]  w_st;

    assign w_iss_oh = addr_onehot(iss_n);
    assign w_wx_oh  = addr_onehot(wx_n);
    assign w_wy_oh  = addr_onehot(wy_n);

    assign iss_full = iss_en & w_full[iss_n];
    assign busy     = ~w_zero;
    assign rd_stall = |w_st;

    for (genvar g = 0; g < NREG; g++) begin : g_ctr
        logic       w_inc;
        logic [1:0] w_dec;
        assign w_inc = iss_en & w_iss_oh[g] & ~iss_full;
        assign w_dec = {1'b0, wx_en & w_wx_oh[g]} + {1'b0, wy_en & wy_pend & w_wy_oh[g]};
        fpr_pending_ctr #(.CW(CW)) u_ctr (
            .clk    (clk),
            .i_clrn (clrn),
            .i_inc  (w_inc),
            .i_dec  (w_dec),
            .o_zero (w_zero[g]),
            .o_full (w_full[g])
        );
    end

    for (genvar p = 0; p < NRD; p++) begin : g_qd
        assign qd[p*DW +: DW] = w_q[p];
    end

    // Register array write; X wins over Y when both target the same register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wy_en && !(wx_en && (wx_n == wy_n))) begin
                r_mem[wy_n] <= wy_d;
            end
            if (wx_en) begin
                r_mem[wx_n] <= wx_d;
            end
        end
    end

    // Per-port read: youngest matching FPU stage, then same-cycle write, then scoreboard, then array.
    always_comb begin : read_mux
        logic          v_hit;
        logic [AW-1:0] v_a;
        v_hit = 1'b0;
        v_a   = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            v_a    = rn[p*AW +: AW];
            v_hit  = 1'b0;
            w_q[p] = r_mem[v_a];
            w_st[p] = 1'b0;
            if (rd_en[p]) begin
                for (int unsigned i = 0; i < NFWD; i++) begin
                    if (!v_hit && fwd_v[i] && (fwd_n[i*AW +: AW] == v_a)) begin
                        v_hit = 1'b1;
                        if (fwd_rdy[i]) begin
                            w_q[p] = fwd_d[i*DW +: DW];
                        end else begin
                            w_st[p] = 1'b1;
                        end
                    end
                end
                if (!v_hit) begin
                    if (wx_en && (wx_n == v_a)) begin
                        w_q[p] = wx_d;
                    end else if (wy_en && (wy_n == v_a)) begin
                        w_q[p] = wy_d;
                    end else if (!w_zero[v_a]) begin
                        w_st[p] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fpr_scoreboard_rf.sv
// Self-checking bench for fpr_scoreboard_rf: directed cases plus randomized traffic vs. a reference model.
module tb_fpr_scoreboard_rf;

    logic        clk;
    logic        clrn;
    logic [1:0]  rd_en;
    logic [9:0]  rn;
    logic [63:0] qd;
    logic        rd_stall;
    logic        iss_en;
    logic [4:0]  iss_n;
    logic        iss_full;
    logic        wx_en;
    logic [4:0]  wx_n;
    logic [31:0] wx_d;
    logic        wy_en;
    logic [4:0]  wy_n;
    logic [31:0] wy_d;
    logic        wy_pend;
    logic [2:0]  fwd_v;
    logic [2:0]  fwd_rdy;
    logic [14:0] fwd_n;
    logic [95:0] fwd_d;
    logic [31:0] busy;

    int unsigned total;
    int unsigned bad;

    // Reference state: register contents and number of in-flight writes per register.
    logic [31:0] mem [32];
    int unsigned cnt [32];

    fpr_scoreboard_rf #(
        .DW(32), .NREG(32), .AW(5), .NRD(2), .NFWD(3), .CW(2)
    ) dut (
        .clk(clk), .clrn(clrn),
        .rd_en(rd_en), .rn(rn), .qd(qd), .rd_stall(rd_stall),
        .iss_en(iss_en), .iss_n(iss_n), .iss_full(iss_full),
        .wx_en(wx_en), .wx_n(wx_n), .wx_d(wx_d),
        .wy_en(wy_en), .wy_n(wy_n), .wy_d(wy_d), .wy_pend(wy_pend),
        .fwd_v(fwd_v), .fwd_rdy(fwd_rdy), .fwd_n(fwd_n), .fwd_d(fwd_d),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        clrn = 1'b1; rd_en = '0; rn = '0;
        iss_en = 1'b0; iss_n = '0;
        wx_en = 1'b0; wx_n = '0; wx_d = '0;
        wy_en = 1'b0; wy_n = '0; wy_d = '0; wy_pend = 1'b0;
        fwd_v = '0; fwd_rdy = '0; fwd_n = '0; fwd_d = '0;
    endtask

    // Compare all outputs against the model mid-cycle.
    task automatic settle();
        logic [31:0] eq;
        logic        est;
        logic        any;
        logic        hit;
        logic [31:0] eb;
        int unsigned a;
        @(negedge clk);
        any = 1'b0;
        for (int p = 0; p < 2; p++) begin
            a = rn[p*5 +: 5];
            eq = mem[a];
            est = 1'b0;
            if (rd_en[p]) begin
                hit = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (!hit && fwd_v[i] && fwd_n[i*5 +: 5] == a[4:0]) begin
                        hit = 1'b1;
                        if (fwd_rdy[i]) eq = fwd_d[i*32 +: 32];
                        else            est = 1'b1;
                    end
                end
                if (!hit) begin
                    if (wx_en && wx_n == a[4:0])      eq = wx_d;
                    else if (wy_en && wy_n == a[4:0]) eq = wy_d;
                    else if (cnt[a] != 0)             est = 1'b1;
                end
            end
            if (!est) check($sformatf("qd%0d", p), 64'(qd[p*32 +: 32]), 64'(eq));
            any = any | est;
        end
        check("rd_stall", 64'(rd_stall), 64'(any));
        check("iss_full", 64'(iss_full), 64'(iss_en && cnt[iss_n] == 3));
        for (int r = 0; r < 32; r++) eb[r] = (cnt[r] != 0);
        check("busy", 64'(busy), 64'(eb));
    endtask

    // Advance one clock and update the model, then return inputs to idle.
    task automatic commit();
        @(posedge clk);
        if (!clrn) begin
            for (int r = 0; r < 32; r++) begin mem[r] = '0; cnt[r] = 0; end
        end else begin
            if (wy_en) mem[wy_n] = wy_d;
            if (wx_en) mem[wx_n] = wx_d;
            if (iss_en && cnt[iss_n] < 3) cnt[iss_n]++;
            if (wx_en && cnt[wx_n] > 0) cnt[wx_n]--;
            if (wy_en && wy_pend && cnt[wy_n] > 0) cnt[wy_n]--;
        end
        #1;
        clear_inputs();
    endtask

    task automatic cycle();
        settle();
        commit();
    endtask

    task automatic issue(input logic [4:0] n);
        iss_en = 1'b1; iss_n = n;
        cycle();
    endtask

    task automatic retire_x(input logic [4:0] n, input logic [31:0] d);
        wx_en = 1'b1; wx_n = n; wx_d = d;
        cycle();
    endtask

    task automatic rand_cycle();
        int unsigned avail [32];
        int unsigned n;
        if ($urandom_range(0, 63) == 0) clrn = 1'b0;
        rd_en = 2'($urandom);
        rn = {2'b0, 3'($urandom), 2'b0, 3'($urandom)};
        fwd_v = 3'($urandom);
        fwd_rdy = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
            fwd_n[i*5 +: 5] = 5'($urandom_range(0, 7));
            fwd_d[i*32 +: 32] = $urandom;
        end
        for (int r = 0; r < 32; r++) avail[r] = cnt[r];
        if ($urandom_range(0, 9) < 4) begin
            iss_en = 1'b1;
            iss_n = 5'($urandom_range(0, 7));
            if (cnt[iss_n] < 3) avail[iss_n]++;
        end
        if ($urandom_range(0, 1) == 1) begin
            n = $urandom_range(0, 7);
            if (avail[n] > 0) begin
                wx_en = 1'b1; wx_n = 5'(n); wx_d = $urandom;
                avail[n]--;
            end
        end
        if ($urandom_range(0, 2) == 0) begin
            n = $urandom_range(0, 7);
            wy_en = 1'b1; wy_n = 5'(n); wy_d = $urandom;
            wy_pend = (avail[n] > 0) && ($urandom_range(0, 1) == 1);
        end
        cycle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int r = 0; r < 32; r++) begin mem[r] = '0; cnt[r] = 0; end
        clear_inputs();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_inputs();

        // Reset state visible on both read ports.
        rd_en = 2'b11; rn = {5'd1, 5'd0};
        settle();
        check("rst_qd", qd, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        commit();

        // Same-cycle bypass of an X write, then array read.
        issue(5'd5);
        wx_en = 1'b1; wx_n = 5'd5; wx_d = 32'h3F800000;
        rd_en = 2'b01; rn = {5'd0, 5'd5};
        settle();
        check("byp_r5", 64'(qd[31:0]), 64'h3F800000);
        commit();
        rd_en = 2'b01; rn = {5'd0, 5'd5};
        settle();
        check("arr_r5", 64'(qd[31:0]), 64'h3F800000);
        commit();

        // Forwarding stage not ready stalls, ready supplies data.
        issue(5'd7);
        fwd_v = 3'b100; fwd_n[10 +: 5] = 5'd7; fwd_rdy = 3'b000;
        rd_en = 2'b10; rn = {5'd7, 5'd0};
        settle();
        check("fwd_notrdy", 64'(rd_stall), 64'h1);
        commit();
        fwd_v = 3'b100; fwd_n[10 +: 5] = 5'd7; fwd_rdy = 3'b100; fwd_d[64 +: 32] = 32'h40000000;
        rd_en = 2'b10; rn = {5'd7, 5'd0};
        settle();
        check("fwd_rdy_st", 64'(rd_stall), 64'h0);
        check("fwd_rdy_qd", 64'(qd[63:32]), 64'h40000000);
        commit();

        // Youngest matching stage wins.
        fwd_v = 3'b101; fwd_rdy = 3'b101;
        fwd_n = {5'd3, 5'd12, 5'd3};
        fwd_d = {32'hBBBBBBBB, 32'h0, 32'hAAAAAAAA};
        rd_en = 2'b01; rn = {5'd0, 5'd3};
        settle();
        check("fwd_prio", 64'(qd[31:0]), 64'hAAAAAAAA);
        commit();

        // Counter saturation and iss_full.
        issue(5'd9); issue(5'd9); issue(5'd9);
        iss_en = 1'b1; iss_n = 5'd9;
        settle();
        check("iss_full_r9", 64'(iss_full), 64'h1);
        commit();
        for (int k = 0; k < 3; k++) begin
            wx_en = 1'b1; wx_n = 5'd9; wx_d = 32'(k);
            settle();
            check("busy9_before", 64'(busy[9]), 64'h1);
            commit();
        end
        settle();
        check("busy9_after", 64'(busy[9]), 64'h0);
        commit();

        // Issue and retire in the same cycle leaves the count unchanged.
        issue(5'd4);
        iss_en = 1'b1; iss_n = 5'd4;
        retire_x(5'd4, 32'h12345678);
        settle();
        check("busy4_held", 64'(busy[4]), 64'h1);
        commit();
        retire_x(5'd4, 32'h9ABCDEF0);
        settle();
        check("busy4_done", 64'(busy[4]), 64'h0);
        commit();

        // Double write collision: X data lands, both retire.
        issue(5'd2); issue(5'd2);
        wx_en = 1'b1; wx_n = 5'd2; wx_d = 32'h11111111;
        wy_en = 1'b1; wy_n = 5'd2; wy_d = 32'h22222222; wy_pend = 1'b1;
        cycle();
        rd_en = 2'b01; rn = {5'd0, 5'd2};
        settle();
        check("coll_r2", 64'(qd[31:0]), 64'h11111111);
        check("coll_busy2", 64'(busy[2]), 64'h0);
        commit();

        // Reset while counters are nonzero.
        issue(5'd11); issue(5'd11);
        clrn = 1'b0;
        cycle();
        rd_en = 2'b11; rn = {5'd2, 5'd5};
        settle();
        check("clr_busy", 64'(busy), 64'h0);
        check("clr_qd", qd, 64'h0);
        commit();

        for (int k = 0; k < 3000; k++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
